// File: rtl/combination_lock_ctrl.sv
// combination_lock_ctrl
//   Supervisory controller for a serial-entry combination lock. Digit strobes
//   are collected into a code word and compared with the stored code. The lock
//   is then sequenced through entry, a timed unlock and a timed penalty
//   lockout. Consecutive wrong codes are counted.
//
//   Optional feature macro: COMBO_LOCK_PROG_EN. When it is defined, the
//   stored code can be reprogrammed while the lock is open, and the prog port
//   exists. When it is undefined, the code is fixed at DEFAULT_CODE.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   zero      in   digit-0 strobe (one digit per high cycle)
//   one       in   digit-1 strobe
//   relock    in   forces OPEN back to ENTRY
//   prog      in   arm code programming while OPEN (COMBO_LOCK_PROG_EN only)
//   unlock    out  actuator drive, registered
//   lockout   out  penalty lockout active, registered
//   fail      out  one-cycle pulse per wrong code
//   fail_cnt  out  consecutive-failure count
//
// Strobe semantics: no handshake. Each cycle with exactly one of zero/one
// high is one digit. Both high is an invalid key.
module combination_lock_ctrl #(
  parameter int                CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 5'b01011,
  parameter int                MAX_FAILS      = 3,
  parameter int                FAIL_W         = 2,
  parameter int                UNLOCK_CYCLES  = 50,
  parameter int                LOCKOUT_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zero,
  input  logic              one,
  input  logic              relock,
`ifdef COMBO_LOCK_PROG_EN
  input  logic              prog,
`endif
  output logic              unlock,
  output logic              lockout,
  output logic              fail,
  output logic [FAIL_W-1:0] fail_cnt
);

  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // Timers count down to zero. The output is held for one extra cycle while
  // the timer sits at zero, so loading N-1 gives exactly N high cycles.
  localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT   = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    dig_cnt;
  logic [CODE_LEN-2:0] entry_sr;   // earlier digits only; the current digit completes the word
  logic [TMR_W-1:0]    timer;

  logic                key_valid;
  logic                key_bad;
  logic [CODE_LEN-1:0] entry_word;
  logic [FAIL_W-1:0]   fail_inc;
  logic [CODE_LEN-1:0] code;

  assign key_valid  = zero ^ one;
  assign key_bad    = zero & one;
  assign entry_word = {entry_sr, one};
  assign fail_inc   = fail_cnt + 1'b1;

`ifdef COMBO_LOCK_PROG_EN
  logic                armed;
  logic [CNT_W-1:0]    stg_cnt;
  logic [CODE_LEN-2:0] stg_sr;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] stg_word;

  assign stg_word = {stg_sr, one};
  assign code     = code_q;
`else
  assign code     = DEFAULT_CODE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ENTRY;
      unlock   <= 1'b0;
      lockout  <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= '0;
      dig_cnt  <= '0;
      entry_sr <= '0;
      timer    <= '0;
`ifdef COMBO_LOCK_PROG_EN
      armed    <= 1'b0;
      stg_cnt  <= '0;
      stg_sr   <= '0;
      code_q   <= DEFAULT_CODE;
`endif
    end else begin
      fail <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (key_bad) begin
            dig_cnt <= '0;
          end else if (key_valid) begin
            entry_sr <= entry_word[CODE_LEN-2:0];
            if (dig_cnt == LAST_DIGIT) begin
              dig_cnt <= '0;
              if (entry_word == code) begin
                state    <= ST_OPEN;
                unlock   <= 1'b1;
                timer    <= UNLOCK_LOAD;
                fail_cnt <= '0;
`ifdef COMBO_LOCK_PROG_EN
                armed    <= 1'b0;
`endif
              end else begin
                fail     <= 1'b1;
                fail_cnt <= fail_inc;
                if (fail_inc == FAIL_LIMIT) begin
                  state   <= ST_LOCKOUT;
                  lockout <= 1'b1;
                  timer   <= LOCKOUT_LOAD;
                end
              end
            end else begin
              dig_cnt <= dig_cnt + 1'b1;
            end
          end
        end

        ST_OPEN: begin
          // relock and expiry both leave; either one aborts programming.
          if (relock || (timer == '0)) begin
            state  <= ST_ENTRY;
            unlock <= 1'b0;
`ifdef COMBO_LOCK_PROG_EN
            armed  <= 1'b0;
`endif
          end else begin
            timer <= timer - 1'b1;
`ifdef COMBO_LOCK_PROG_EN
            if (prog) begin
              armed   <= 1'b1;
              stg_cnt <= '0;
            end else if (armed) begin
              if (key_bad) begin
                stg_cnt <= '0;
              end else if (key_valid) begin
                stg_sr <= stg_word[CODE_LEN-2:0];
                if (stg_cnt == LAST_DIGIT) begin
                  code_q  <= stg_word;
                  stg_cnt <= '0;
                  armed   <= 1'b0;
                  state   <= ST_ENTRY;
                  unlock  <= 1'b0;
                end else begin
                  stg_cnt <= stg_cnt + 1'b1;
                end
              end
            end
`endif
          end
        end

        ST_LOCKOUT: begin
          if (timer == '0) begin
            state    <= ST_ENTRY;
            lockout  <= 1'b0;
            fail_cnt <= '0;
            dig_cnt  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state   <= ST_ENTRY;
          unlock  <= 1'b0;
          lockout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_combination_lock_ctrl.sv
// Testbench for combination_lock_ctrl. The test exercises these features:
//   - directed scenarios for entry, failures, lockout, invalid key, relock and
//     reset;
//   - code programming, when COMBO_LOCK_PROG_EN is defined;
//   - a randomized phase.
// A behavioural model predicts all outputs after every clock edge. The model
// keeps the digits in queues and keeps "remaining high cycles" counters.
module tb_combination_lock_ctrl;

  localparam int UL = 8;
  localparam int LO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zero = 1'b0;
  logic       one = 1'b0;
  logic       relock = 1'b0;
  logic       prog_s = 1'b0;
  logic       unlock;
  logic       lockout;
  logic       fail;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  combination_lock_ctrl #(
    .CODE_LEN(5), .DEFAULT_CODE(5'b01011), .MAX_FAILS(3), .FAIL_W(2),
    .UNLOCK_CYCLES(UL), .LOCKOUT_CYCLES(LO)
  ) dut (
    .clk(clk), .rst(rst), .zero(zero), .one(one), .relock(relock),
`ifdef COMBO_LOCK_PROG_EN
    .prog(prog_s),
`endif
    .unlock(unlock), .lockout(lockout), .fail(fail), .fail_cnt(fail_cnt)
  );

  // ---------------- reference model ----------------
  int         m_ul;      // remaining unlock-high cycles
  int         m_lo;      // remaining lockout-high cycles
  int         m_fails;
  bit         m_fail;
  bit         m_armed;
  logic [4:0] m_code;
  int         dq[$];     // digits of the code being entered
  int         sq[$];     // digits being programmed

  function automatic logic [4:0] pack_dq();
    logic [4:0] w = '0;
    foreach (dq[i]) w = {w[3:0], dq[i][0]};
    return w;
  endfunction

  function automatic logic [4:0] pack_sq();
    logic [4:0] w = '0;
    foreach (sq[i]) w = {w[3:0], sq[i][0]};
    return w;
  endfunction

  task automatic model_reset();
    m_ul = 0; m_lo = 0; m_fails = 0; m_fail = 0; m_armed = 0;
    m_code = 5'b01011;
    dq.delete(); sq.delete();
  endtask

  task automatic model_step(input logic z, input logic o, input logic r, input logic p);
    m_fail = 0;
    if (m_lo > 0) begin
      m_lo--;
      if (m_lo == 0) begin
        m_fails = 0;
        dq.delete();
      end
    end else if (m_ul > 0) begin
      if (r || m_ul == 1) begin
        m_ul = 0;
        m_armed = 0;
      end else begin
        m_ul--;
`ifdef COMBO_LOCK_PROG_EN
        if (p) begin
          m_armed = 1;
          sq.delete();
        end else if (m_armed) begin
          if (z && o) sq.delete();
          else if (z != o) begin
            sq.push_back(int'(o));
            if (sq.size() == 5) begin
              m_code = pack_sq();
              sq.delete();
              m_ul = 0;
              m_armed = 0;
            end
          end
        end
`else
        if (p) m_armed = 0;
`endif
      end
    end else begin
      if (z && o) dq.delete();
      else if (z != o) begin
        dq.push_back(int'(o));
        if (dq.size() == 5) begin
          if (pack_dq() == m_code) begin
            m_ul = UL;
            m_fails = 0;
          end else begin
            m_fail = 1;
            m_fails++;
            if (m_fails == 3) m_lo = LO;
          end
          dq.delete();
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".unlock"},   32'(unlock),   32'(m_ul > 0));
    check({tag, ".lockout"},  32'(lockout),  32'(m_lo > 0));
    check({tag, ".fail"},     32'(fail),     32'(m_fail));
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fails));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic z, input logic o, input logic r, input logic p);
    zero = z; one = o; relock = r; prog_s = p;
    @(posedge clk);
    model_step(z, o, r, p);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [4:0] c);
    for (int i = 4; i >= 0; i--) cycle(~c[i], c[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; zero = 0; one = 0; relock = 0; prog_s = 0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst.unlock",   32'(unlock),   32'd0);
    check("rst.lockout",  32'(lockout),  32'd0);
    check("rst.fail",     32'(fail),     32'd0);
    check("rst.fail_cnt", 32'(fail_cnt), 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    int fails_seen;
    model_reset();
    @(negedge clk);

    // 1: correct code, unlock for exactly UL cycles
    do_reset();
    enter(5'b01011);
    check("t1.unlock_first", 32'(unlock), 32'd1);
    check("t1.fail", 32'(fail), 32'd0);
    hi = int'(unlock);
    for (int i = 0; i < 11; i++) begin
      cycle(0, 0, 0, 0);
      hi += int'(unlock);
    end
    check("t1.unlock_len", 32'(hi), 32'(UL));
    check("t1.fail_cnt", 32'(fail_cnt), 32'd0);

    // 2: three wrong codes -> lockout, digits ignored during lockout
    fails_seen = 0;
    for (int k = 1; k <= 3; k++) begin
      enter(5'b01111);
      fails_seen += int'(fail);
      check("t2.fail_cnt_step", 32'(fail_cnt), 32'(k));
      idle(1);
    end
    check("t2.fail_pulses", 32'(fails_seen), 32'd3);
    // lockout rose with the third fail; one idle cycle already spent
    hi = 2;
    check("t2.lockout_on", 32'(lockout), 32'd1);
    for (int i = 4; i >= 0; i--) begin
      cycle(~5'b01011 >> i & 1'b1, 5'b01011 >> i & 1'b1, 0, 0);
      check("t2.no_unlock", 32'(unlock), 32'd0);
      hi += int'(lockout);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0);
      hi += int'(lockout);
    end
    check("t2.lockout_len", 32'(hi), 32'(LO));
    check("t2.fail_cnt_clr", 32'(fail_cnt), 32'd0);
    enter(5'b01011);
    check("t2.unlock_after", 32'(unlock), 32'd1);
    idle(UL + 1);

    // 3: invalid key clears partial entry
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    enter(5'b01011);
    check("t3.unlock", 32'(unlock), 32'd1);
    check("t3.fail", 32'(fail), 32'd0);
    idle(UL + 1);
    enter(5'b00000);
    check("t3.fail_cnt1", 32'(fail_cnt), 32'd1);
    enter(5'b01011);
    check("t3.fail_cnt0", 32'(fail_cnt), 32'd0);
    idle(UL + 1);

    // 4: relock on OPEN cycle 3, then reset mid-entry
    enter(5'b01011);
    idle(2);
    cycle(0, 0, 1, 0);
    check("t4.relock", 32'(unlock), 32'd0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    do_reset();
    enter(5'b01011);
    check("t4.unlock_after_rst", 32'(unlock), 32'd1);
    idle(UL + 1);

`ifdef COMBO_LOCK_PROG_EN
    // 5: program 11001
    enter(5'b01011);
    cycle(0, 0, 0, 1);
    enter(5'b11001);
    check("t5.prog_done", 32'(unlock), 32'd0);
    idle(1);
    enter(5'b01011);
    check("t5.old_fails", 32'(fail), 32'd1);
    enter(5'b11001);
    check("t5.new_unlocks", 32'(unlock), 32'd1);
    idle(UL + 1);
    do_reset();
    enter(5'b01011);
    check("t5.rst_restores", 32'(unlock), 32'd1);
    idle(UL + 1);

    // 6: programming aborted by expiry
    enter(5'b01011);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(UL);
    enter(5'b01011);
    check("t6.code_kept", 32'(unlock), 32'd1);
    idle(UL + 1);
`endif

    // randomized phase
    for (int it = 0; it < 400; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 2) enter(m_code);
      else if (act < 4) enter(5'($urandom_range(0, 31)));
      else if (act == 4 && it == 200) do_reset();
      else begin
        int n;
        n = $urandom_range(1, 8);
        for (int j = 0; j < n; j++) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 40)      cycle(0, 0, 0, 0);
          else if (r < 60) cycle(1, 0, 0, 0);
          else if (r < 80) cycle(0, 1, 0, 0);
          else if (r < 85) cycle(1, 1, 0, 0);
          else if (r < 93) cycle(1'($urandom_range(0, 1)), 0, 1, 0);
`ifdef COMBO_LOCK_PROG_EN
          else             cycle(0, 0, 0, 1);
`else
          else             cycle(0, 0, 0, 0);
`endif
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
